aludec_issue: RTL and testbench

- Registered, multi-lane successor to the combinational ALU-control decoder.
- Sits between decode and execute. Decodes up to LANES instructions per cycle into `EXE_*_OP` alucontrol codes and holds them in one output register.
- Carries a HI/LO scoreboard: MULT/DIV latency is counted down, and HI/LO readers and writers are held until it expires.
- Uses a valid/ready handshake on both sides and a flush input.

---
 rtl/aludec_issue_pkg.sv | 120 ++++++++++++
 rtl/aludec_lane.sv | 110 +++++++++++
 rtl/aludec_issue.sv | 147 ++++++++++++++
 tb/tb_aludec_issue.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aludec_issue_pkg.sv
// aludec_issue_pkg: shared constants for the registered ALU-control issue stage.
// Holds the EXE_*_OP alucontrol table, MIPS opcode/funct/rs/rt field values,
// the class-bit indices and the lane decode record.
package aludec_issue_pkg;

  // alucontrol codes
  localparam logic [4:0] EXE_AND_OP     = 5'b00000;
  localparam logic [4:0] EXE_OR_OP      = 5'b00001;
  localparam logic [4:0] EXE_XOR_OP     = 5'b00010;
  localparam logic [4:0] EXE_NOR_OP     = 5'b00011;
  localparam logic [4:0] EXE_LUI_OP     = 5'b00100;
  localparam logic [4:0] EXE_SLL_OP     = 5'b00101;
  localparam logic [4:0] EXE_SRL_OP     = 5'b00110;
  localparam logic [4:0] EXE_SRA_OP     = 5'b00111;
  localparam logic [4:0] EXE_SLLV_OP    = 5'b01000;
  localparam logic [4:0] EXE_SRLV_OP    = 5'b01001;
  localparam logic [4:0] EXE_SRAV_OP    = 5'b01010;
  localparam logic [4:0] EXE_MFHI_OP    = 5'b01011;
  localparam logic [4:0] EXE_MTHI_OP    = 5'b01100;
  localparam logic [4:0] EXE_MFLO_OP    = 5'b01101;
  localparam logic [4:0] EXE_MTLO_OP    = 5'b01110;
  localparam logic [4:0] EXE_SLT_OP     = 5'b01111;
  localparam logic [4:0] EXE_SLTU_OP    = 5'b10000;
  localparam logic [4:0] EXE_ADD_OP     = 5'b10001;
  localparam logic [4:0] EXE_ADDU_OP    = 5'b10010;
  localparam logic [4:0] EXE_SUB_OP     = 5'b10011;
  localparam logic [4:0] EXE_SUBU_OP    = 5'b10100;
  localparam logic [4:0] EXE_MULT_OP    = 5'b10101;
  localparam logic [4:0] EXE_OP3F_OP    = 5'b10110;
  localparam logic [4:0] EXE_MULTU_OP   = 5'b10111;
  localparam logic [4:0] EXE_DIV_OP     = 5'b11000;
  localparam logic [4:0] EXE_DIVU_OP    = 5'b11001;
  localparam logic [4:0] EXE_MTC0_OP    = 5'b11010;
  localparam logic [4:0] EXE_MFC0_OP    = 5'b11011;
  localparam logic [4:0] EXE_USELESS_OP = 5'b11111;

  // class-bit indices inside lane_dec_t.cls
  localparam int CLS_MD = 0;
  localparam int CLS_HL = 1;

  // opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_3F      = 6'b111111;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;
  localparam logic [5:0] FN_ERET    = 6'h18;

  // REGIMM rt and COP0 rs selectors
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] RS_MF      = 5'h00;
  localparam logic [4:0] RS_MT      = 5'h04;
  localparam logic [4:0] RS_CO      = 5'h10;

  typedef struct packed {
    logic [4:0] op;
    logic [1:0] cls;
    logic       ri;
  } lane_dec_t;

  // DIV/DIVU occupy HI/LO longer than MULT/MULTU
  function automatic logic is_div_funct(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/aludec_lane.sv
// aludec_lane: combinational decode of one instruction into its alucontrol
// code plus the HI/LO class bits (md, hl) and the reserved-instruction flag.
module aludec_lane #(
  parameter int CW = 5
) (
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  output logic [CW-1:0] alucontrol,
  output logic          md,
  output logic          hl,
  output logic          ri
);
  import aludec_issue_pkg::*;

  lane_dec_t dec;

  // table lookup: anything not listed is reserved
  always_comb begin
    dec = '{op: EXE_USELESS_OP, cls: 2'b00, ri: 1'b0};
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_SLL:  dec.op = EXE_SLL_OP;
          FN_SRL:  dec.op = EXE_SRL_OP;
          FN_SRA:  dec.op = EXE_SRA_OP;
          FN_SLLV: dec.op = EXE_SLLV_OP;
          FN_SRLV: dec.op = EXE_SRLV_OP;
          FN_SRAV: dec.op = EXE_SRAV_OP;
          FN_JR, FN_SYSCALL, FN_BREAK: dec.op = EXE_USELESS_OP;
          FN_JALR: dec.op = EXE_ADDU_OP;
          FN_MFHI: begin dec.op = EXE_MFHI_OP; dec.cls[CLS_HL] = 1'b1; end
          FN_MTHI: begin dec.op = EXE_MTHI_OP; dec.cls[CLS_HL] = 1'b1; end
          FN_MFLO: begin dec.op = EXE_MFLO_OP; dec.cls[CLS_HL] = 1'b1; end
          FN_MTLO: begin dec.op = EXE_MTLO_OP; dec.cls[CLS_HL] = 1'b1; end
          FN_MULT: begin
            dec.op = EXE_MULT_OP;
            dec.cls[CLS_MD] = 1'b1;
            dec.cls[CLS_HL] = 1'b1;
          end
          FN_MULTU: begin
            dec.op = EXE_MULTU_OP;
            dec.cls[CLS_MD] = 1'b1;
            dec.cls[CLS_HL] = 1'b1;
          end
          FN_DIV: begin
            dec.op = EXE_DIV_OP;
            dec.cls[CLS_MD] = 1'b1;
            dec.cls[CLS_HL] = 1'b1;
          end
          FN_DIVU: begin
            dec.op = EXE_DIVU_OP;
            dec.cls[CLS_MD] = 1'b1;
            dec.cls[CLS_HL] = 1'b1;
          end
          FN_ADD:  dec.op = EXE_ADD_OP;
          FN_ADDU: dec.op = EXE_ADDU_OP;
          FN_SUB:  dec.op = EXE_SUB_OP;
          FN_SUBU: dec.op = EXE_SUBU_OP;
          FN_AND:  dec.op = EXE_AND_OP;
          FN_OR:   dec.op = EXE_OR_OP;
          FN_XOR:  dec.op = EXE_XOR_OP;
          FN_NOR:  dec.op = EXE_NOR_OP;
          FN_SLT:  dec.op = EXE_SLT_OP;
          FN_SLTU: dec.op = EXE_SLTU_OP;
          default: dec.ri = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     dec.op = EXE_USELESS_OP;
          RT_BLTZAL, RT_BGEZAL: dec.op = EXE_ADDU_OP;
          default:              dec.ri = 1'b1;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec.op = EXE_USELESS_OP;
      OP_JAL:   dec.op = EXE_ADDU_OP;
      OP_ADDI:  dec.op = EXE_ADD_OP;
      OP_ADDIU: dec.op = EXE_ADDU_OP;
      OP_SLTI:  dec.op = EXE_SLT_OP;
      OP_SLTIU: dec.op = EXE_SLTU_OP;
      OP_ANDI:  dec.op = EXE_AND_OP;
      OP_ORI:   dec.op = EXE_OR_OP;
      OP_XORI:  dec.op = EXE_XOR_OP;
      OP_LUI:   dec.op = EXE_LUI_OP;
      OP_COP0: begin
        if (rs == RS_MT) begin
          dec.op = EXE_MTC0_OP;
        end else if (rs == RS_MF) begin
          dec.op = EXE_MFC0_OP;
        end else if (rs == RS_CO && funct == FN_ERET) begin
          dec.op = EXE_USELESS_OP;
        end else begin
          dec.ri = 1'b1;
        end
      end
      // address generation for memory ops
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: dec.op = EXE_ADDU_OP;
      OP_3F:    dec.op = EXE_OP3F_OP;
      default:  dec.ri = 1'b1;
    endcase
  end

  assign alucontrol = CW'(dec.op);
  assign md         = dec.cls[CLS_MD];
  assign hl         = dec.cls[CLS_HL];
  assign ri         = dec.ri;

endmodule

// File: rtl/aludec_issue.sv
// aludec_issue: registered multi-lane ALU-control decoder between decode and
// execute. Takes an in-order prefix of the offered lanes, holds HI/LO users
// while a MULT/DIV is still occupying HI/LO, and presents one output bundle
// under a valid/ready handshake with flush.
// Optional feature: define ALUDEC_PERF_EN to add the stall_cnt output.
module aludec_issue #(
  parameter int LANES   = 2,
  parameter int DIV_LAT = 32,
  parameter int MUL_LAT = 2,
  parameter int CW      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*32-1:0] in_instr,
  input  logic [LANES-1:0]    in_valid,
  output logic [LANES-1:0]    in_take,
  input  logic                flush,
  output logic [LANES*CW-1:0] out_alucontrol,
  output logic [LANES-1:0]    out_valid,
  output logic [LANES-1:0]    out_ri,
  input  logic                out_ready,
  output logic                hilo_busy
`ifdef ALUDEC_PERF_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  import aludec_issue_pkg::*;

  localparam logic [CW-1:0] USELESS_CW = CW'(EXE_USELESS_OP);
  localparam logic [5:0]    DIV_LAT6   = 6'(DIV_LAT);
  localparam logic [5:0]    MUL_LAT6   = 6'(MUL_LAT);

  logic [CW-1:0]       dec_code [LANES];
  logic [LANES-1:0]    dec_md;
  logic [LANES-1:0]    dec_hl;
  logic [LANES-1:0]    dec_ri;
  logic [LANES-1:0]    dec_div;

  logic                load;
  logic [LANES-1:0]    take_next;
  logic                chain_ok;
  logic                md_seen;
  logic                div_seen;
  logic [LANES*CW-1:0] alu_next;
  logic [5:0]          cnt_reg;
  logic [5:0]          cnt_next;

  // one decoder per lane; immediate/shamt bits do not affect the code
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [31:0] word;
    logic        word_unused;
    assign word        = in_instr[32*gi +: 32];
    assign word_unused = ^word[15:6];
    assign dec_div[gi] = is_div_funct(word[5:0]);

    aludec_lane #(.CW(CW)) u_lane (
      .op         (word[31:26]),
      .funct      (word[5:0]),
      .rs         (word[25:21]),
      .rt         (word[20:16]),
      .alucontrol (dec_code[gi]),
      .md         (dec_md[gi]),
      .hl         (dec_hl[gi]),
      .ri         (dec_ri[gi])
    );
  end

  // register accepts a new bundle when empty or drained, unless flushed
  assign load = (!(|out_valid) || out_ready) && !flush;

  // in-order take chain; an hl lane waits on a busy counter or an older md
  always_comb begin
    chain_ok  = load;
    md_seen   = 1'b0;
    div_seen  = 1'b0;
    take_next = '0;
    for (int k = 0; k < LANES; k++) begin
      chain_ok     = chain_ok && in_valid[k] &&
                     !(dec_hl[k] && ((cnt_reg != 6'd0) || md_seen));
      take_next[k] = chain_ok;
      div_seen     = div_seen || (chain_ok && dec_md[k] && dec_div[k]);
      md_seen      = md_seen || (chain_ok && dec_md[k]);
    end
  end

  assign in_take = take_next;

  // codes of untaken lanes are parked at the no-op value
  always_comb begin
    alu_next = {LANES{USELESS_CW}};
    for (int k = 0; k < LANES; k++) begin
      if (take_next[k]) begin
        alu_next[k*CW +: CW] = dec_code[k];
      end
    end
  end

  // output bundle: flush clears, load replaces, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= '0;
      out_ri         <= '0;
      out_alucontrol <= {LANES{USELESS_CW}};
    end else if (flush) begin
      out_valid      <= '0;
    end else if (load) begin
      out_valid      <= take_next;
      out_ri         <= take_next & dec_ri;
      out_alucontrol <= alu_next;
    end
  end

  // HI/LO occupancy: a fresh md take reloads, else count down to zero
  always_comb begin
    cnt_next = cnt_reg;
    if (md_seen) begin
      cnt_next = div_seen ? DIV_LAT6 : MUL_LAT6;
    end else if (cnt_reg != 6'd0) begin
      cnt_next = cnt_reg - 6'd1;
    end
  end

  // counter and its registered busy flag; flush leaves both alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= 6'd0;
      hilo_busy <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      hilo_busy <= (cnt_next != 6'd0);
    end
  end

`ifdef ALUDEC_PERF_EN
  // count cycles where the oldest offered instruction could not be taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (in_valid[0] && !take_next[0] && !flush &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aludec_issue.sv
// tb_aludec_issue: randomized + directed bench for aludec_issue (LANES=2,
// DIV_LAT=4, MUL_LAT=2). The driver models the upstream queue and the issue
// rules at instruction level and pushes expected bundles into a scoreboard;
// a negedge monitor pops and compares each bundle as it leaves the register.
module tb_aludec_issue;
  import aludec_issue_pkg::*;

  localparam int LANES = 2;
  localparam int DIVL  = 4;
  localparam int MULL  = 2;
  localparam int CW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [LANES*32-1:0] in_instr;
  logic [LANES-1:0]    in_valid;
  logic [LANES-1:0]    in_take;
  logic                flush;
  logic [LANES*CW-1:0] out_alucontrol;
  logic [LANES-1:0]    out_valid;
  logic [LANES-1:0]    out_ri;
  logic                out_ready;
  logic                hilo_busy;
`ifdef ALUDEC_PERF_EN
  logic [31:0]         stall_cnt;
`endif

  aludec_issue #(.LANES(LANES), .DIV_LAT(DIVL), .MUL_LAT(MULL), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_instr       (in_instr),
    .in_valid       (in_valid),
    .in_take        (in_take),
    .flush          (flush),
    .out_alucontrol (out_alucontrol),
    .out_valid      (out_valid),
    .out_ri         (out_ri),
    .out_ready      (out_ready),
    .hilo_busy      (hilo_busy)
`ifdef ALUDEC_PERF_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [4:0] c0;
    logic [4:0] c1;
    logic [1:0] ri;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          rtab[64];
  int          itab[64];
  int          rlist[$];
  int          ilist[$];
  int          mlist[$];

  int          checks = 0;
  int          errors = 0;
  int          m_cnt = 0;
  bit          m_vis = 0;
  longint      m_stall = 0;
  logic [1:0]  last_take;
  bit          hold_prev = 0;
  logic [9:0]  prev_alu;
  logic [1:0]  prev_v;
  logic [1:0]  prev_ri;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction-set table: -1 marks a reserved encoding
  function automatic void build_tables();
    for (int i = 0; i < 64; i++) begin rtab[i] = -1; itab[i] = -1; end
    rtab['h00] = EXE_SLL_OP;  rtab['h02] = EXE_SRL_OP;  rtab['h03] = EXE_SRA_OP;
    rtab['h04] = EXE_SLLV_OP; rtab['h06] = EXE_SRLV_OP; rtab['h07] = EXE_SRAV_OP;
    rtab['h08] = EXE_USELESS_OP; rtab['h09] = EXE_ADDU_OP;
    rtab['h0C] = EXE_USELESS_OP; rtab['h0D] = EXE_USELESS_OP;
    rtab['h10] = EXE_MFHI_OP; rtab['h11] = EXE_MTHI_OP;
    rtab['h12] = EXE_MFLO_OP; rtab['h13] = EXE_MTLO_OP;
    rtab['h18] = EXE_MULT_OP; rtab['h19] = EXE_MULTU_OP;
    rtab['h1A] = EXE_DIV_OP;  rtab['h1B] = EXE_DIVU_OP;
    rtab['h20] = EXE_ADD_OP;  rtab['h21] = EXE_ADDU_OP;
    rtab['h22] = EXE_SUB_OP;  rtab['h23] = EXE_SUBU_OP;
    rtab['h24] = EXE_AND_OP;  rtab['h25] = EXE_OR_OP;
    rtab['h26] = EXE_XOR_OP;  rtab['h27] = EXE_NOR_OP;
    rtab['h2A] = EXE_SLT_OP;  rtab['h2B] = EXE_SLTU_OP;
    itab['h02] = EXE_USELESS_OP; itab['h03] = EXE_ADDU_OP;
    for (int i = 4; i < 8; i++) itab[i] = EXE_USELESS_OP;
    itab['h08] = EXE_ADD_OP;  itab['h09] = EXE_ADDU_OP;
    itab['h0A] = EXE_SLT_OP;  itab['h0B] = EXE_SLTU_OP;
    itab['h0C] = EXE_AND_OP;  itab['h0D] = EXE_OR_OP;
    itab['h0E] = EXE_XOR_OP;  itab['h0F] = EXE_LUI_OP;
    foreach (mlist[i]) itab[mlist[i]] = EXE_ADDU_OP;
    itab['h3F] = 5'b10110;
  endfunction

  function automatic void ref_decode(input logic [31:0] w, output int code,
                                     output bit md, output bit hl, output bit ri);
    int op, fn, rs, rt;
    op = int'(w[31:26]); fn = int'(w[5:0]); rs = int'(w[25:21]); rt = int'(w[20:16]);
    code = EXE_USELESS_OP; md = 0; hl = 0; ri = 0;
    if (op == 0) begin
      if (rtab[fn] < 0) ri = 1; else code = rtab[fn];
      md = (fn >= 'h18 && fn <= 'h1B);
      hl = md || (fn >= 'h10 && fn <= 'h13);
    end else if (op == 1) begin
      if (rt == 16 || rt == 17) code = EXE_ADDU_OP;
      else if (rt > 1) ri = 1;
    end else if (op == 'h10) begin
      if (rs == 4) code = EXE_MTC0_OP;
      else if (rs == 0) code = EXE_MFC0_OP;
      else if (!(rs == 16 && fn == 'h18)) ri = 1;
    end else begin
      if (itab[op] < 0) ri = 1; else code = itab[op];
    end
  endfunction

  function automatic logic [31:0] rtype(input int fn);
    logic [31:0] w;
    w = $urandom; w[31:26] = 6'h00; w[5:0] = 6'(fn);
    return w;
  endfunction

  function automatic logic [31:0] itype(input int op);
    logic [31:0] w;
    w = $urandom; w[31:26] = 6'(op);
    return w;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: w = rtype(rlist[$urandom_range(0, rlist.size() - 1)]);
      3:       w[31:26] = 6'h00;
      4, 5:    w = itype(ilist[$urandom_range(0, ilist.size() - 1)]);
      6:       begin w[31:26] = 6'h01; w[20:16] = ($urandom_range(0, 1) == 1) ? 5'h10 : 5'($urandom_range(0, 3)); end
      7:       begin w[31:26] = 6'h10; w[25:21] = 5'($urandom_range(0, 4) * 4); if ($urandom_range(0, 1) == 1) w[5:0] = 6'h18; end
      8:       w = itype(mlist[$urandom_range(0, mlist.size() - 1)]);
      default: if ($urandom_range(0, 1) == 1) w[31:26] = 6'h3F;
    endcase
    return w;
  endfunction

  // one cycle of upstream offer, reference issue model and take check
  task automatic step(input int nv, input bit rdy, input bit fl);
    int n, ntk;
    logic [31:0] lanew [2];
    logic [1:0]  vmask, mtake;
    bit          ok, load, md_seen, div_seen;
    int          code [2];
    bit          md [2], hl [2], ri [2];
    exp_t        e;
    @(posedge clk); #1;
    chk("hilo_busy", hilo_busy, (m_cnt != 0));
`ifdef ALUDEC_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    n = (nv > prog.size()) ? prog.size() : nv;
    vmask = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    for (int k = 0; k < 2; k++) lanew[k] = (k < n) ? prog[k] : rand_instr();
    in_instr = {lanew[1], lanew[0]};
    in_valid = vmask; out_ready = rdy; flush = fl;
    #1;
    load = (!m_vis || rdy) && !fl;
    ok = load; md_seen = 0; div_seen = 0; mtake = 2'b00; ntk = 0;
    for (int k = 0; k < 2; k++) begin
      ref_decode(lanew[k], code[k], md[k], hl[k], ri[k]);
      ok = ok && vmask[k] && !(hl[k] && (m_cnt != 0 || md_seen));
      mtake[k] = ok;
      if (ok) ntk++;
      if (ok && md[k]) begin
        md_seen = 1;
        div_seen = (lanew[k][5:0] == 6'h1A) || (lanew[k][5:0] == 6'h1B);
      end
    end
    chk("in_take", in_take, mtake);
    last_take = in_take;
    if (fl) m_vis = 0;
    else if (load) begin
      m_vis = (ntk != 0);
      if (ntk != 0) begin
        e.v = mtake; e.c0 = 5'(code[0]); e.c1 = 5'(code[1]);
        e.ri = {ri[1] && mtake[1], ri[0] && mtake[0]};
        sb.push_back(e);
      end
    end
    if (md_seen) m_cnt = div_seen ? DIVL : MULL;
    else if (m_cnt > 0) m_cnt--;
    if (vmask[0] && !mtake[0] && !fl && m_stall < 64'hFFFF_FFFF) m_stall++;
    for (int k = 0; k < ntk; k++) void'(prog.pop_front());
  endtask

  task automatic async_reset_check();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hilo_busy", hilo_busy, 0);
    chk("rst_out_ri", out_ri, 0);
    chk("rst_out_alu", out_alucontrol, {EXE_USELESS_OP, EXE_USELESS_OP});
`ifdef ALUDEC_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    in_valid = 2'b00; flush = 1'b0; out_ready = 1'b1;
    #1;
    rst = 1'b0;
    m_cnt = 0; m_vis = 0; m_stall = 0; hold_prev = 0;
    sb.delete(); prog.delete();
  endtask

  // monitor: holding rule, and compare each bundle on its last visible cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 0;
      end else begin
        if (hold_prev) begin
          checks++;
          if (out_valid !== prev_v || out_ri !== prev_ri || out_alucontrol !== prev_alu) begin
            errors++;
            $display("FAIL hold: got v=%b ri=%b alu=%h expected v=%b ri=%b alu=%h",
                     out_valid, out_ri, out_alucontrol, prev_v, prev_ri, prev_alu);
          end
        end
        if (out_valid != 2'b00 && (out_ready || flush)) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bundle: got v=%b expected none", out_valid);
          end else begin
            e = sb.pop_front();
            $display("bundle v=%b alu0=%0d alu1=%0d ri=%b flush=%0b", out_valid,
                     out_alucontrol[4:0], out_alucontrol[9:5], out_ri, flush);
            chk("out_valid", out_valid, e.v);
            if (e.v[0]) begin
              chk("alu_lane0", out_alucontrol[4:0], e.c0);
              chk("ri_lane0", out_ri[0], e.ri[0]);
            end
            if (e.v[1]) begin
              chk("alu_lane1", out_alucontrol[9:5], e.c1);
              chk("ri_lane1", out_ri[1], e.ri[1]);
            end
          end
        end
        hold_prev = (out_valid != 2'b00) && !out_ready && !flush;
        prev_v = out_valid; prev_ri = out_ri; prev_alu = out_alucontrol;
      end
    end
  end

  initial begin
    int held;
    rlist = '{'h00, 'h02, 'h03, 'h04, 'h06, 'h07, 'h08, 'h09, 'h10, 'h11, 'h12, 'h13,
              'h18, 'h19, 'h1A, 'h1B, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h2A};
    ilist = '{'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F};
    mlist = '{'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B};
    build_tables();
    rst = 1'b1; in_instr = '0; in_valid = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_ri", out_ri, 0);
    chk("reset_out_alu", out_alucontrol, {EXE_USELESS_OP, EXE_USELESS_OP});
    chk("reset_hilo_busy", hilo_busy, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ADDU + ORI dual issue
    prog.push_back(rtype('h21)); prog.push_back(itype('h0D));
    step(2, 1, 0);
    chk("dual_take", last_take, 2'b11);
    step(0, 1, 0);

    // DIV with MFLO behind it: MFLO waits DIV_LAT cycles
    prog.push_back(rtype('h1A)); prog.push_back(rtype('h12));
    step(2, 1, 0);
    chk("div_mflo_take", last_take, 2'b01);
    held = 0;
    for (int i = 0; i < 10 && prog.size() > 0; i++) begin
      step(2, 1, 0);
      if (last_take == 2'b00) held++;
    end
    chk("mflo_hold_cycles", held, DIVL);
    chk("mflo_issued", prog.size(), 0);

    // backpressure for three cycles, then release
    for (int i = 0; i < 4; i++) prog.push_back(rtype('h24 + i));
    step(2, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(2, 0, 0);
      chk("stall_take", last_take, 2'b00);
    end
    step(2, 1, 0);
    chk("release_take", last_take, 2'b11);
    step(0, 1, 0);

    // flush the MULT bundle; counter keeps running 2 -> 1 -> 0
    prog.push_back(rtype('h18));
    step(1, 1, 0);
    step(0, 0, 1);
    prog.push_back(rtype('h10));
    step(1, 1, 0);
    chk("mfhi_wait", last_take, 2'b00);
    step(1, 1, 0);
    chk("mfhi_go", last_take, 2'b01);
    step(0, 1, 0);

    // reserved opcode 0x3E next to opcode 0x3F
    prog.push_back(itype('h3E)); prog.push_back(itype('h3F));
    step(2, 1, 0);
    step(0, 1, 0);

    // asynchronous reset while a DIV holds HI/LO
    prog.push_back(rtype('h1B));
    step(1, 1, 0);
    step(0, 0, 0);
    async_reset_check();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      while (prog.size() < 4) prog.push_back(rand_instr());
      step($urandom_range(0, 2), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    // drain
    prog.delete();
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
